// File: rtl/pc_call_stack.sv
// Program counter with a LIFO return-address stack, driven by decoder flow-control strobes.
// Optional build macro CALL_STACK_WRAP_EN makes the stack circular (no overflow fault).
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_RUN   | normal stepping: sequential, jump, call, return when en=1
// S_FAULT | pc, stack and fault_code frozen, fault=1; left only via rst
module pc_call_stack #(
    parameter int PC_WIDTH        = 5,
    parameter int INSTR_ADDR_SIZE = 5,
    parameter int STACK_DEPTH     = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic                               jmp,
    input  logic                               cal,
    input  logic                               ret,
    input  logic                               push,
    input  logic                               pop,
    input  logic [INSTR_ADDR_SIZE-1:0]         jmp_addr,
    output logic [PC_WIDTH-1:0]                pc,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level,
    output logic                               fault,
    output logic [1:0]                         fault_code
);

    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int LVL_W = $clog2(STACK_DEPTH + 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(STACK_DEPTH);

    localparam logic [4:0] T_SEQ  = 5'b00000;
    localparam logic [4:0] T_JMP  = 5'b00100;
    localparam logic [4:0] T_CALL = 5'b10110;
    localparam logic [4:0] T_RET  = 5'b01001;

    localparam logic [1:0] FC_OVERFLOW  = 2'b01;
    localparam logic [1:0] FC_UNDERFLOW = 2'b10;
    localparam logic [1:0] FC_ILLEGAL   = 2'b11;

    typedef enum logic {S_RUN, S_FAULT} state_t;

    state_t                  state_q, state_d;
    logic [PC_WIDTH-1:0]     stack_mem [STACK_DEPTH];
    logic [PTR_W-1:0]        top_ptr, top_ptr_d, pop_ptr;
    logic [PC_WIDTH-1:0]     pc_d, pc_inc, jmp_target;
    logic [LVL_W-1:0]        level_d;
    logic [1:0]              code_d;
    logic                    push_we;
    logic [4:0]              ctrl;

    // jmp_addr is zero-extended or truncated to the pc width
    generate
        if (INSTR_ADDR_SIZE >= PC_WIDTH) begin : g_trunc
            assign jmp_target = jmp_addr[PC_WIDTH-1:0];
        end else begin : g_zext
            assign jmp_target = {{(PC_WIDTH-INSTR_ADDR_SIZE){1'b0}}, jmp_addr};
        end
    endgenerate

    assign ctrl    = {push, pop, jmp, cal, ret};
    assign pc_inc  = pc + 1'b1;
    assign pop_ptr = top_ptr - 1'b1;
    assign fault   = (state_q == S_FAULT);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc;
        level_d   = stack_level;
        top_ptr_d = top_ptr;
        code_d    = fault_code;
        push_we   = 1'b0;
        if (state_q == S_RUN && en) begin
            case (ctrl)
                T_SEQ: pc_d = pc_inc;
                T_JMP: pc_d = jmp_target;
                T_CALL: begin
`ifdef CALL_STACK_WRAP_EN
                    // Full stack overwrites the oldest entry; level saturates
                    push_we   = 1'b1;
                    top_ptr_d = top_ptr + 1'b1;
                    pc_d      = jmp_target;
                    if (stack_level != LVL_FULL) level_d = stack_level + 1'b1;
`else
                    if (stack_level == LVL_FULL) begin
                        state_d = S_FAULT;
                        code_d  = FC_OVERFLOW;
                    end else begin
                        push_we   = 1'b1;
                        top_ptr_d = top_ptr + 1'b1;
                        level_d   = stack_level + 1'b1;
                        pc_d      = jmp_target;
                    end
`endif
                end
                T_RET: begin
                    if (stack_level == '0) begin
                        state_d = S_FAULT;
                        code_d  = FC_UNDERFLOW;
                    end else begin
                        pc_d      = stack_mem[pop_ptr];
                        top_ptr_d = pop_ptr;
                        level_d   = stack_level - 1'b1;
                    end
                end
                default: begin
                    state_d = S_FAULT;
                    code_d  = FC_ILLEGAL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_RUN;
            pc          <= '0;
            stack_level <= '0;
            top_ptr     <= '0;
            fault_code  <= 2'b00;
        end else begin
            state_q     <= state_d;
            pc          <= pc_d;
            stack_level <= level_d;
            top_ptr     <= top_ptr_d;
            fault_code  <= code_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STACK_DEPTH; i++) stack_mem[i] <= '0;
        end else if (push_we) begin
            stack_mem[top_ptr] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_pc_call_stack.sv
// Directed bench for pc_call_stack (PC_WIDTH=5, STACK_DEPTH=4); honours CALL_STACK_WRAP_EN.
module tb_pc_call_stack;

    localparam logic [4:0] T_SEQ  = 5'b00000;
    localparam logic [4:0] T_JMP  = 5'b00100;
    localparam logic [4:0] T_CALL = 5'b10110;
    localparam logic [4:0] T_RET  = 5'b01001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       jmp = 1'b0, cal = 1'b0, ret = 1'b0, push = 1'b0, pop = 1'b0;
    logic [4:0] jmp_addr = '0;
    logic [4:0] pc;
    logic [2:0] stack_level;
    logic       fault;
    logic [1:0] fault_code;

    int n_checks = 0;
    int n_pass   = 0;

    pc_call_stack #(.PC_WIDTH(5), .INSTR_ADDR_SIZE(5), .STACK_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .en(en), .jmp(jmp), .cal(cal), .ret(ret),
        .push(push), .pop(pop), .jmp_addr(jmp_addr), .pc(pc),
        .stack_level(stack_level), .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Apply one tuple {push,pop,jmp,cal,ret} across one rising edge, sample 1 time unit later
    task automatic step(input logic [4:0] tup, input logic [4:0] addr, input logic e);
        {push, pop, jmp, cal, ret} = tup;
        jmp_addr = addr;
        en = e;
        @(posedge clk);
        #1;
        {push, pop, jmp, cal, ret} = 5'b0;
        en = 1'b0;
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        // 1: reset and sequential stepping
        #12 rst = 1'b0;
        #1;
        check("rst_pc", pc, 0);
        check("rst_level", stack_level, 0);
        check("rst_fault", fault, 0);
        check("rst_code", fault_code, 0);
        step(T_SEQ, 5'd0, 1'b1); check("seq_pc1", pc, 1);
        step(T_SEQ, 5'd0, 1'b1); check("seq_pc2", pc, 2);
        step(T_SEQ, 5'd0, 1'b1); check("seq_pc3", pc, 3);
        check("seq_fault", fault, 0);

        // 2: call and return
        step(T_CALL, 5'd20, 1'b1);
        check("call_pc", pc, 20);
        check("call_level", stack_level, 1);
        step(T_RET, 5'd0, 1'b1);
        check("ret_pc", pc, 4);
        check("ret_level", stack_level, 0);

        // 3: nested calls up to and past full
        rst_pulse();
        for (int i = 0; i < 4; i++) step(T_CALL, 5'(10 + i), 1'b1);
        check("nest4_pc", pc, 13);
        check("nest4_level", stack_level, 4);
        step(T_CALL, 5'd14, 1'b1);
`ifdef CALL_STACK_WRAP_EN
        check("wrap_pc", pc, 14);
        check("wrap_level", stack_level, 4);
        check("wrap_fault", fault, 0);
        step(T_RET, 5'd0, 1'b1);
        check("wrap_ret1_pc", pc, 14);
        check("wrap_ret1_level", stack_level, 3);
        step(T_RET, 5'd0, 1'b1);
        check("wrap_ret2_pc", pc, 13);
`else
        check("ovf_fault", fault, 1);
        check("ovf_code", fault_code, 1);
        check("ovf_pc", pc, 13);
        check("ovf_level", stack_level, 4);
`endif

        // 4: underflow, then fault holds
        rst_pulse();
        step(T_JMP, 5'd7, 1'b1);
        check("jmp_pc", pc, 7);
        step(T_RET, 5'd0, 1'b1);
        check("udf_fault", fault, 1);
        check("udf_code", fault_code, 2);
        check("udf_pc", pc, 7);
        step(T_CALL, 5'd3, 1'b1);
        check("frozen_pc", pc, 7);
        check("frozen_level", stack_level, 0);
        check("frozen_code", fault_code, 2);

        // 5: illegal tuple, then asynchronous reset mid-cycle
        rst_pulse();
        step(T_JMP, 5'd5, 1'b1);
        step(5'b11000, 5'd0, 1'b1);
        check("ill_fault", fault, 1);
        check("ill_code", fault_code, 3);
        check("ill_pc", pc, 5);
        #2 rst = 1'b1;
        #1;
        check("arst_pc", pc, 0);
        check("arst_level", stack_level, 0);
        check("arst_fault", fault, 0);
        check("arst_code", fault_code, 0);
        rst = 1'b0;
        #1;

        // 6: pc+1 wrap on call, en=0 hold
        step(T_JMP, 5'd31, 1'b1);
        check("j31_pc", pc, 31);
        step(T_CALL, 5'd2, 1'b1);
        check("c31_pc", pc, 2);
        check("c31_level", stack_level, 1);
        step(T_RET, 5'd0, 1'b1);
        check("rwrap_pc", pc, 0);
        check("rwrap_level", stack_level, 0);
        step(T_JMP, 5'd9, 1'b0);
        check("en0_pc", pc, 0);
        check("en0_fault", fault, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
